// File: rtl/seed_leaf_streamer.sv
`default_nettype none
// ============================================================================
// Module   : seed_leaf_streamer
// Purpose  : Runs the seed tree once per round, latches the 1024-bit seed_star
//            when the tree finishes, splits it into 128-bit leaf seeds and
//            streams them (leaf 0 = MSBs) over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seed_leaf_streamer #(
  parameter int NUM_ROUNDS = 8,
  parameter int NUM_LEAVES = 8,
  parameter int LEAF_W     = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  output logic                         o_tree_start,
  output logic [7:0]                   o_tree_t,
  input  logic                         i_tree_set_end,
  input  logic [NUM_LEAVES*LEAF_W-1:0] i_seed_star,
  output logic [LEAF_W-1:0]            o_leaf_seed,
  output logic [2:0]                   o_leaf_idx,
  output logic [7:0]                   o_leaf_round,
  output logic                         o_leaf_valid,
  input  logic                         i_leaf_ready,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int         c_BUF_W      = NUM_LEAVES * LEAF_W;
  localparam logic [7:0] c_LAST_ROUND = 8'(NUM_ROUNDS - 1);
  localparam logic [2:0] c_LAST_LEAF  = 3'(NUM_LEAVES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_REL    = 3'd2,
    S_STREAM = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_BUF_W-1:0]   r_buf;
  logic [2:0]           r_idx;
  logic [7:0]           r_round;
  logic                 w_accept;
  logic                 w_last_leaf;
  logic                 w_last_round;
  logic [LEAF_W-1:0]    w_leaf;

  assign w_accept     = (r_state == S_STREAM) && i_leaf_ready;
  assign w_last_leaf  = (r_idx == c_LAST_LEAF);
  assign w_last_round = (r_round == c_LAST_ROUND);

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived control outputs.
  always_comb begin
    w_next       = r_state;
    o_tree_start = 1'b0;
    o_leaf_valid = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        o_tree_start = 1'b1;
        if (i_tree_set_end) begin
          w_next = S_REL;
        end
      end
      S_REL: begin
        // Wait for the tree to clear its done flag so it is not mistaken
        // for the next round's completion.
        if (!i_tree_set_end) begin
          w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        o_leaf_valid = 1'b1;
        if (i_leaf_ready && w_last_leaf) begin
          w_next = w_last_round ? S_FIN : S_REQ;
        end
      end
      S_FIN: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Seed buffer, leaf index and round counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf   <= '0;
      r_idx   <= 3'd0;
      r_round <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_round <= 8'd0;
            r_idx   <= 3'd0;
          end
        end
        S_REQ: begin
          if (i_tree_set_end) begin
            r_buf <= i_seed_star;
          end
        end
        S_REL: begin
          r_idx <= 3'd0;
        end
        S_STREAM: begin
          if (w_accept) begin
            if (w_last_leaf) begin
              r_idx <= 3'd0;
              if (!w_last_round) begin
                r_round <= r_round + 8'd1;
              end
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Select the current leaf from the buffer; leaf 0 occupies the MSBs.
  always_comb begin
    w_leaf = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (r_idx == 3'(i)) begin
        w_leaf = r_buf[c_BUF_W-1-i*LEAF_W -: LEAF_W];
      end
    end
  end

  assign o_leaf_seed  = w_leaf;
  assign o_leaf_idx   = r_idx;
  assign o_leaf_round = r_round;
  assign o_tree_t     = r_round;

endmodule
`default_nettype wire

// File: tb/tb_seed_leaf_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seed_leaf_streamer
// Purpose  : Directed bench for seed_leaf_streamer with a behavioural seed
//            tree and a leaf scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seed_leaf_streamer;

  localparam int c_ROUNDS   = 3;
  localparam int c_TREE_LAT = 5;

  typedef struct {
    logic [127:0] seed;
    logic [2:0]   idx;
    logic [7:0]   rnd;
  } leaf_t;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic          o_tree_start;
  logic [7:0]    o_tree_t;
  logic          i_tree_set_end;
  logic [1023:0] i_seed_star;
  logic [127:0]  o_leaf_seed;
  logic [2:0]    o_leaf_idx;
  logic [7:0]    o_leaf_round;
  logic          o_leaf_valid;
  logic          i_leaf_ready;
  logic          o_busy;
  logic          o_done;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    rise_cyc = 0;
  int    hold_cfg = 0;
  int    acc_cnt, done_cnt, valid_cyc, ts_rise;
  logic  [7:0] run_id = 8'd0;
  leaf_t exp_q[$];
  logic  [7:0] t_seen[$];
  logic  prev_ts = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;

  seed_leaf_streamer #(
    .NUM_ROUNDS(c_ROUNDS),
    .NUM_LEAVES(8),
    .LEAF_W(128)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_start(i_start),
    .o_tree_start(o_tree_start),
    .o_tree_t(o_tree_t),
    .i_tree_set_end(i_tree_set_end),
    .i_seed_star(i_seed_star),
    .o_leaf_seed(o_leaf_seed),
    .o_leaf_idx(o_leaf_idx),
    .o_leaf_round(o_leaf_round),
    .o_leaf_valid(o_leaf_valid),
    .i_leaf_ready(i_leaf_ready),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaf i of round r: nibble i repeated, round in low byte, run id in top byte.
  function automatic logic [127:0] leaf_val(input logic [7:0] r, input int i, input logic [7:0] id);
    logic [3:0] n;
    n = 4'(i);
    return {32{n}} ^ {120'd0, r} ^ {id, 120'd0};
  endfunction

  // Behavioural seed tree: fixed latency, holds set_end until tree_start
  // drops plus hold_cfg cycles, scrambling seed_star during the extra hold.
  initial begin
    logic [7:0]    t;
    logic [1023:0] s;
    leaf_t         e;
    int            n;
    i_tree_set_end = 1'b0;
    i_seed_star    = '0;
    forever begin
      @(negedge clk);
      if (!reset && o_tree_start && !i_tree_set_end) begin
        t = o_tree_t;
        t_seen.push_back(t);
        repeat (c_TREE_LAT - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          e.seed = leaf_val(t, i, run_id);
          e.idx  = 3'(i);
          e.rnd  = t;
          s[1023-128*i -: 128] = e.seed;
          exp_q.push_back(e);
        end
        i_seed_star    = s;
        i_tree_set_end = 1'b1;
        rise_cyc       = cyc;
        n = 0;
        while (o_tree_start && n < 100) begin
          @(negedge clk);
          n++;
        end
        for (int h = 0; h < hold_cfg; h++) begin
          i_seed_star = {32{$urandom()}};
          @(negedge clk);
        end
        i_tree_set_end = 1'b0;
        i_seed_star    = {32{$urandom()}};
      end
    end
  end

  // Output monitor: scoreboard on accepted leaves, pulse/edge bookkeeping.
  always @(negedge clk) begin
    leaf_t e;
    if (!reset) begin
      if (o_leaf_valid) valid_cyc++;
      if (o_leaf_valid && !prev_valid)
        chk("first_leaf_latency", 128'(cyc - rise_cyc), 128'(2 + hold_cfg));
      if (o_leaf_valid && i_leaf_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk("leaf_unexpected", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("leaf_seed", o_leaf_seed, e.seed);
          chk("leaf_idx", 128'(o_leaf_idx), 128'(e.idx));
          chk("leaf_round", 128'(o_leaf_round), 128'(e.rnd));
        end
      end
      if (o_tree_start && !prev_ts) ts_rise++;
      if (o_done) done_cnt++;
      if (prev_done) chk("done_one_cycle", 128'(o_done), 128'd0);
    end
    prev_ts    = o_tree_start;
    prev_valid = o_leaf_valid;
    prev_done  = o_done;
  end

  task automatic clear_counts();
    acc_cnt = 0; done_cnt = 0; valid_cyc = 0; ts_rise = 0;
    t_seen.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input logic start_in_fin);
    int n;
    n = 0;
    while (!o_done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 128'(o_done), 128'd1);
    chk("busy_in_fin", 128'(o_busy), 128'd1);
    if (start_in_fin) i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_done", 128'(o_busy), 128'd0);
    chk("done_low_after", 128'(o_done), 128'd0);
  endtask

  task automatic end_of_run(input int vcyc);
    chk("leaves_accepted", 128'(acc_cnt), 128'd24);
    chk("valid_cycles", 128'(valid_cyc), 128'(vcyc));
    chk("done_count", 128'(done_cnt), 128'd1);
    chk("tree_start_rises", 128'(ts_rise), 128'(c_ROUNDS));
    chk("tree_t_count", 128'(t_seen.size()), 128'(c_ROUNDS));
    for (int i = 0; i < t_seen.size(); i++)
      chk("tree_t_order", 128'(t_seen[i]), 128'(i));
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tree_start", 128'(o_tree_start), 128'd0);
    chk("rst_tree_t", 128'(o_tree_t), 128'd0);
    chk("rst_leaf_valid", 128'(o_leaf_valid), 128'd0);
    chk("rst_leaf_idx", 128'(o_leaf_idx), 128'd0);
    chk("rst_leaf_round", 128'(o_leaf_round), 128'd0);
    chk("rst_leaf_seed", o_leaf_seed, 128'd0);
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_done", 128'(o_done), 128'd0);
  endtask

  initial begin
    int n;
    logic [127:0] held_seed;
    reset = 1'b1; i_start = 1'b0; i_leaf_ready = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b0;

    // Run 1: ready always high, back-to-back leaves.
    run_id = 8'd0; hold_cfg = 0; clear_counts();
    pulse_start();
    wait_done(1'b0);
    end_of_run(24);

    // Run 2: backpressure for 4 cycles at leaf 3 of round 0.
    run_id = 8'd1; clear_counts();
    pulse_start();
    n = 0;
    while (!(o_leaf_valid && o_leaf_idx == 3'd3) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reached_idx3", 128'(o_leaf_valid && o_leaf_idx == 3'd3), 128'd1);
    held_seed = o_leaf_seed;
    i_leaf_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_idx_held", 128'(o_leaf_idx), 128'd3);
      chk("bp_seed_held", o_leaf_seed, held_seed);
      chk("bp_valid_held", 128'(o_leaf_valid), 128'd1);
    end
    i_leaf_ready = 1'b1;
    wait_done(1'b0);
    end_of_run(28);

    // Run 3: tree holds set_end 3 extra cycles; start pulsed in STREAM and FIN.
    run_id = 8'd2; hold_cfg = 3; clear_counts();
    pulse_start();
    n = 0;
    while (!o_leaf_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_restart_busy", 128'(o_busy), 128'd0);
      chk("no_restart_tree_start", 128'(o_tree_start), 128'd0);
    end
    end_of_run(24);

    // Run 4: reset at round 1 leaf 5, then a clean full run.
    run_id = 8'd3; hold_cfg = 0; clear_counts();
    pulse_start();
    n = 0;
    while (!(o_leaf_valid && o_leaf_round == 8'd1 && o_leaf_idx == 3'd5) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_point_reached", 128'(o_leaf_valid && o_leaf_round == 8'd1 && o_leaf_idx == 3'd5), 128'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs();
    reset = 1'b0;
    exp_q.delete();
    run_id = 8'd4; clear_counts();
    pulse_start();
    wait_done(1'b0);
    end_of_run(24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
